led_pwm_ctrl: RTL and testbench



---
 rtl/led_pwm_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_pwm_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_ctrl.sv
// Multi-channel MMIO LED controller: per-channel PWM brightness, blink gating and register readback.
// Pending duties are promoted to the active set only at PWM wrap, so every PWM period is whole.

module led_pwm_ctrl #(
  parameter int unsigned NUM_CH      = 6,
  parameter logic [15:0] BASE_ADDR   = 16'hFF10,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned BLINK_SHIFT = 16,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       mmio_addr,
  input  logic [7:0]        mmio_wdata,
  input  logic              mmio_we,
  input  logic              mmio_req,
  output logic              mmio_done,
  output logic [7:0]        mmio_rdata,
  output logic [NUM_CH-1:0] led
);

  localparam logic [15:0]       OFF_ENABLE = 16'd0;
  localparam logic [15:0]       OFF_BLINK  = 16'd1;
  localparam logic [15:0]       OFF_RATE   = 16'd2;
  localparam logic [15:0]       OFF_LAST   = 16'(2 + NUM_CH);
  localparam logic [NUM_CH-1:0] LED_OFF    = {NUM_CH{ACTIVE_LOW}};

  typedef logic [PWM_BITS-1:0] duty_t;

  logic [15:0]            offset;
  logic                   in_range, access, wr_en, rd_en;
  logic                   tick, pwm_wrap;
  logic [7:0]             rd_val;
  logic [NUM_CH-1:0]      ch_on;

  logic [NUM_CH-1:0]      enable_q, enable_d;
  logic [NUM_CH-1:0]      blink_q, blink_d;
  logic [7:0]             rate_q, rate_d;
  duty_t [NUM_CH-1:0]     duty_pend_q, duty_pend_d;
  duty_t [NUM_CH-1:0]     duty_act_q, duty_act_d;
  duty_t                  pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_SHIFT-1:0] presc_q, presc_d;
  logic [7:0]             tick_cnt_q, tick_cnt_d;
  logic                   phase_q, phase_d;
  logic                   done_q, done_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [NUM_CH-1:0]      led_q, led_d;

  // The lower-bound compare keeps addresses below BASE_ADDR from wrapping into range.
  assign offset   = mmio_addr - BASE_ADDR;
  assign in_range = (mmio_addr >= BASE_ADDR) && (offset <= OFF_LAST);
  assign access   = mmio_req && in_range;
  assign wr_en    = access && mmio_we;
  assign rd_en    = access && !mmio_we;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    enable_d    = enable_q;
    blink_d     = blink_q;
    rate_d      = rate_q;
    duty_pend_d = duty_pend_q;
    rd_val      = '0;

    case (offset)
      OFF_ENABLE: rd_val = 8'(enable_q);
      OFF_BLINK:  rd_val = 8'(blink_q);
      OFF_RATE:   rd_val = rate_q;
      default:    ;
    endcase
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (offset == 16'(3 + i)) rd_val = 8'(duty_pend_q[i]);
    end

    if (wr_en) begin
      case (offset)
        OFF_ENABLE: enable_d = mmio_wdata[NUM_CH-1:0];
        OFF_BLINK:  blink_d  = mmio_wdata[NUM_CH-1:0];
        OFF_RATE:   rate_d   = mmio_wdata;
        default:    ;
      endcase
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (offset == 16'(3 + i)) duty_pend_d[i] = mmio_wdata[PWM_BITS-1:0];
      end
    end

    done_d  = access;
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  always_comb begin
    pwm_wrap   = (pwm_cnt_q == '1);
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    duty_act_d = pwm_wrap ? duty_pend_q : duty_act_q;

    tick       = (presc_q == '1);
    presc_d    = presc_q + 1'b1;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    // A RATE write restarts the half-period count and wins over a coincident tick.
    if (wr_en && (offset == OFF_RATE)) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      if (tick_cnt_q == rate_q) begin
        tick_cnt_d = '0;
        phase_d    = !phase_q;
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end

    ch_on = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_on[i] = enable_q[i] && (pwm_cnt_q < duty_act_q[i]) && (!blink_q[i] || phase_q);
    end
    led_d = ch_on ^ LED_OFF;
  end

  always_ff @(posedge clock) begin
    // NOTE: state updates are non-blocking so every register samples the pre-edge value of the others.
    if (!reset) begin
      enable_q    <= '0;
      blink_q     <= '0;
      rate_q      <= '0;
      // NOTE: the duty arrays are a handful of flops, not a RAM, so they are reset like any other state.
      duty_pend_q <= '0;
      duty_act_q  <= '0;
      pwm_cnt_q   <= '0;
      presc_q     <= '0;
      tick_cnt_q  <= '0;
      phase_q     <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      led_q       <= LED_OFF;
    end else begin
      enable_q    <= enable_d;
      blink_q     <= blink_d;
      rate_q      <= rate_d;
      duty_pend_q <= duty_pend_d;
      duty_act_q  <= duty_act_d;
      pwm_cnt_q   <= pwm_cnt_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      led_q       <= led_d;
    end
  end

  assign mmio_done  = done_q;
  assign mmio_rdata = rdata_q;
  assign led        = led_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: bus scoreboard, cycle-level LED reference model, duty/blink windows.
// Built with BLINK_SHIFT = 2 so blink periods are a few clocks long.

module tb_led_pwm_ctrl;

  localparam int          NUM_CH  = 6;
  localparam logic [15:0] BASE    = 16'hFF10;
  localparam logic [15:0] A_EN    = BASE;
  localparam logic [15:0] A_BLINK = BASE + 16'd1;
  localparam logic [15:0] A_RATE  = BASE + 16'd2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [15:0]       mmio_addr = '0;
  logic [7:0]        mmio_wdata = '0;
  logic              mmio_we = 1'b0;
  logic              mmio_req = 1'b0;
  logic              mmio_done;
  logic [7:0]        mmio_rdata;
  logic [NUM_CH-1:0] led;

  led_pwm_ctrl #(
    .NUM_CH      (NUM_CH),
    .BASE_ADDR   (BASE),
    .PWM_BITS    (8),
    .BLINK_SHIFT (2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata),
    .mmio_we    (mmio_we),
    .mmio_req   (mmio_req),
    .mmio_done  (mmio_done),
    .mmio_rdata (mmio_rdata),
    .led        (led)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] a_duty(input int i);
    return BASE + 16'(3 + i);
  endfunction

  function automatic bit in_range(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) <= int'(BASE) + 2 + NUM_CH);
  endfunction

  // Scoreboard: one entry per accepted access, due at a given posedge count.
  typedef struct {
    int         due;
    bit         is_rd;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   pe = 0;
  bit   mon_en = 1'b0;

  // Reference model state, advanced at each posedge from the driven inputs.
  logic [NUM_CH-1:0] m_enable = '0;
  logic [NUM_CH-1:0] m_blink = '0;
  logic [7:0]        m_rate = '0;
  logic [7:0]        m_pend [NUM_CH];
  logic [7:0]        m_act  [NUM_CH];
  logic [7:0]        m_pwm = '0;
  logic [1:0]        m_presc = '0;
  logic [7:0]        m_tick = '0;
  logic              m_phase = 1'b0;
  logic [NUM_CH-1:0] m_led = '1;
  logic [7:0]        m_rdata = '0;

  always @(posedge clock) begin
    pe++;
    if (!reset) begin
      m_enable = '0;
      m_blink  = '0;
      m_rate   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = '0;
        m_act[i]  = '0;
      end
      m_pwm   = '0;
      m_presc = '0;
      m_tick  = '0;
      m_phase = 1'b0;
      m_led   = '1;
      m_rdata = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        m_led[i] = !(m_enable[i] && (m_pwm < m_act[i]) && (!m_blink[i] || m_phase));
      if (m_pwm == 8'd255)
        for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
      if (mmio_req && mmio_we && mmio_addr == A_RATE) begin
        m_tick = '0;
      end else if (m_presc == 2'd3) begin
        if (m_tick == m_rate) begin
          m_tick  = '0;
          m_phase = !m_phase;
        end else begin
          m_tick = m_tick + 8'd1;
        end
      end
      if (mmio_req && mmio_we) begin
        if (mmio_addr == A_EN)    m_enable = mmio_wdata[NUM_CH-1:0];
        if (mmio_addr == A_BLINK) m_blink  = mmio_wdata[NUM_CH-1:0];
        if (mmio_addr == A_RATE)  m_rate   = mmio_wdata;
        for (int i = 0; i < NUM_CH; i++)
          if (mmio_addr == a_duty(i)) m_pend[i] = mmio_wdata;
      end
      m_pwm   = m_pwm + 8'd1;
      m_presc = m_presc + 2'd1;
    end
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_en) begin
      check("led", 32'(led), 32'(m_led));
      if (sb_q.size() > 0 && sb_q[0].due == pe) begin
        e = sb_q.pop_front();
        check("done_pulse", 32'(mmio_done), 32'd1);
        if (e.is_rd) begin
          check("rdata", 32'(mmio_rdata), 32'(e.data));
          m_rdata = e.data;
        end else begin
          check("rdata_hold_wr", 32'(mmio_rdata), 32'(m_rdata));
        end
      end else begin
        check("done_idle", 32'(mmio_done), 32'd0);
        check("rdata_hold", 32'(mmio_rdata), 32'(m_rdata));
      end
    end
  end

  task automatic sb_push(input logic [15:0] a, input bit is_rd, input logic [7:0] d, input int ofs);
    if (reset && in_range(a)) sb_q.push_back('{due: pe + 1 + ofs, is_rd: is_rd, data: d});
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    mmio_addr  = a;
    mmio_wdata = d;
    mmio_we    = 1'b1;
    mmio_req   = 1'b1;
    sb_push(a, 1'b0, 8'h00, 0);
    @(negedge clock);
    mmio_req = 1'b0;
    mmio_we  = 1'b0;
  endtask

  task automatic bus_hold_read(input logic [15:0] a, input int n, input logic [7:0] exp);
    mmio_addr = a;
    mmio_we   = 1'b0;
    mmio_req  = 1'b1;
    for (int k = 0; k < n; k++) sb_push(a, 1'b1, exp, k);
    repeat (n) @(negedge clock);
    mmio_req = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp);
    bus_hold_read(a, 1, exp);
  endtask

  int lit_cnt [NUM_CH];

  task automatic count_lit(input int n);
    for (int i = 0; i < NUM_CH; i++) lit_cnt[i] = 0;
    repeat (n) begin
      @(negedge clock);
      for (int i = 0; i < NUM_CH; i++) if (!led[i]) lit_cnt[i]++;
    end
  endtask

  // Waits for channel 0 to go from off to lit (the sample right after pwm_cnt = 0),
  // counting channel-2 lit samples seen before that point.
  task automatic sync_ch0(output bit found, output int ch2_lit);
    logic prev;
    found   = 1'b0;
    ch2_lit = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      prev = led[0];
      @(negedge clock);
      if (prev && !led[0]) found = 1'b1;
      else if (!led[2]) ch2_lit++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int pre;

    repeat (3) @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Reset then idle
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("idle_led", 32'(led), 32'h3F);
      check("idle_done", 32'(mmio_done), 32'd0);
    end
    bus_read(A_EN, 8'h00);

    // Enable mask and 50% duty on channel 0
    bus_write(A_EN, 8'hFF);
    bus_write(a_duty(0), 8'h80);
    bus_read(A_EN, 8'h3F);
    repeat (260) @(negedge clock);
    count_lit(256);
    check("ch0_duty_80", 32'(lit_cnt[0]), 32'd128);
    for (int i = 1; i < NUM_CH; i++) check("chN_duty_0", 32'(lit_cnt[i]), 32'd0);

    // Mid-period duty write must wait for the next wrap
    sync_ch0(found, pre);
    check("sync_first", 32'(found), 32'd1);
    repeat (62) @(negedge clock);
    bus_write(a_duty(2), 8'h40);
    bus_read(a_duty(2), 8'h40);
    sync_ch0(found, pre);
    check("sync_second", 32'(found), 32'd1);
    check("duty2_no_early", 32'(pre), 32'd0);
    check("duty2_at_wrap", 32'(led[2]), 32'd0);
    count_lit(256);
    check("ch2_duty_40", 32'(lit_cnt[2]), 32'd64);
    check("ch0_duty_80_again", 32'(lit_cnt[0]), 32'd128);

    // Blink on channel 0 at full duty, RATE = 1 -> 8-clock half period
    bus_write(a_duty(0), 8'hFF);
    bus_write(A_BLINK, 8'hC1);
    bus_write(A_RATE, 8'h01);
    bus_read(A_BLINK, 8'h01);
    bus_read(A_RATE, 8'h01);
    repeat (260) @(negedge clock);
    count_lit(256);
    check("blink_ch0_half", 32'((lit_cnt[0] == 127) || (lit_cnt[0] == 128)), 32'd1);
    check("ch2_unblinked", 32'(lit_cnt[2]), 32'd64);
    repeat (5) @(negedge clock);
    bus_write(A_RATE, 8'h01);
    repeat (40) @(negedge clock);
    bus_write(A_RATE, 8'h00);
    repeat (40) @(negedge clock);
    bus_read(A_RATE, 8'h00);

    // Address boundaries and held request
    bus_write(BASE + 16'(3 + NUM_CH), 8'hAA);
    bus_write(BASE - 16'd1, 8'hAA);
    bus_read(BASE + 16'(3 + NUM_CH), 8'h00);
    bus_read(BASE - 16'd1, 8'h00);
    bus_read(a_duty(NUM_CH - 1), 8'h00);
    bus_write(a_duty(NUM_CH - 1), 8'h11);
    bus_read(a_duty(NUM_CH - 1), 8'h11);
    bus_read(A_EN, 8'h3F);
    bus_read(A_BLINK, 8'h01);
    bus_hold_read(A_EN, 3, 8'h3F);
    repeat (20) @(negedge clock);

    // Reset mid-operation with a request in flight
    reset     = 1'b0;
    mmio_addr = A_EN;
    mmio_we   = 1'b0;
    mmio_req  = 1'b1;
    @(negedge clock);
    check("rst_led", 32'(led), 32'h3F);
    check("rst_done", 32'(mmio_done), 32'd0);
    check("rst_rdata", 32'(mmio_rdata), 32'h00);
    reset    = 1'b1;
    mmio_req = 1'b0;
    bus_read(A_EN, 8'h00);
    bus_read(a_duty(0), 8'h00);
    bus_read(A_RATE, 8'h00);
    repeat (3) @(negedge clock);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
